// File: rtl/pal_cfg_serializer_if.sv
// -----------------------------------------------------------------------------
// pal_cfg_serializer_if
//
// Signal bundle between a configuration loader and the PAL configuration
// serializer. It carries the byte-stream handshake on the loader side and the
// serial pin-level outputs towards the PAL.
//
// Signals:
//   START       loader -> serializer  begin a load (honoured only when idle)
//   BYTE_DATA   loader -> serializer  configuration byte, bit 0 shifted first
//   BYTE_VALID  loader -> serializer  BYTE_DATA is valid
//   BYTE_READY  serializer -> loader  serializer accepts a byte this cycle
//   CFG_DATA    serializer -> PAL     serial configuration bit (PAL CFG pin)
//   CFG_SCLK    serializer -> PAL     generated shift clock (PAL CLK pin)
//   CFG_EN      serializer -> PAL     apply-enable (PAL EN pin)
//   BUSY        serializer -> loader  a load is in progress
//   DONE        serializer -> loader  one-cycle pulse when a load completes
//
// Modports:
//   master  the loader side (drives START / BYTE_DATA / BYTE_VALID)
//   slave   the serializer side
// -----------------------------------------------------------------------------
interface pal_cfg_serializer_if;
    logic       START;
    logic [7:0] BYTE_DATA;
    logic       BYTE_VALID;
    logic       BYTE_READY;
    logic       CFG_DATA;
    logic       CFG_SCLK;
    logic       CFG_EN;
    logic       BUSY;
    logic       DONE;

    modport master (
        output START,
        output BYTE_DATA,
        output BYTE_VALID,
        input  BYTE_READY,
        input  CFG_DATA,
        input  CFG_SCLK,
        input  CFG_EN,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  START,
        input  BYTE_DATA,
        input  BYTE_VALID,
        output BYTE_READY,
        output CFG_DATA,
        output CFG_SCLK,
        output CFG_EN,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/pal_cfg_serializer.sv
// -----------------------------------------------------------------------------
// pal_cfg_serializer
//
// Transmit end of the PAL configuration chain. Bytes of the configuration
// bitstream arrive over a valid/ready handshake and are shifted out LSB first
// on CFG_DATA, with a locally generated shift clock on CFG_SCLK. Once all
// CFG_LEN bits have been clocked into the PAL, CFG_EN is raised so the fabric
// switches to the new configuration.
//
// Parameters:
//   CFG_LEN  total number of configuration bits per load (280 for N=8,
//            P=14, M=4: 2*N*P AND-plane + P*M OR-plane)
//   CLK_DIV  CFG_SCLK half-period in CLK cycles (>= 1)
//
// Ports:
//   CLK    system clock, all logic on the rising edge
//   RES_N  asynchronous active-low reset; aborts any load in progress
//   bus    pal_cfg_serializer_if.slave (handshake inputs, PAL pin outputs)
//
// Bit timing: each bit takes CLK_DIV cycles with CFG_SCLK low followed by
// CLK_DIV cycles with CFG_SCLK high; the PAL samples on the rising edge.
// CFG_DATA only ever changes on the edge where CFG_SCLK goes (or stays) low,
// which gives CLK_DIV cycles of setup and of hold around every rising edge.
// A fetch of a new byte adds one cycle with CFG_SCLK held low.
//
// In the last byte, bits at positions >= CFG_LEN mod 8 (when nonzero) are
// never shifted: the load ends as soon as CFG_LEN bits have gone out.
//
// All pin-level outputs except BYTE_READY come straight from flops because
// they leave the chip; BYTE_READY is a decode of the state register.
// -----------------------------------------------------------------------------
module pal_cfg_serializer #(
    parameter int CFG_LEN = 280,
    parameter int CLK_DIV = 2
) (
    input  logic                 CLK,
    input  logic                 RES_N,
    pal_cfg_serializer_if.slave  bus
);

    localparam int CNT_W = $clog2(CFG_LEN + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_LEN - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_SLO    = 3'd2;
    localparam logic [2:0] ST_SHI    = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] bit_cnt;   // bits fully clocked into the PAL this load
    logic [2:0]       bit_idx;   // position of the current bit inside its byte
    logic [DIV_W-1:0] div_cnt;   // cycles spent in the current SCLK phase
    logic [7:0]       shreg;     // bit 0 is the bit currently on CFG_DATA

    logic cfg_sclk_q;
    logic cfg_en_q;
    logic busy_q;
    logic done_q;

    // -------------------------------------------------------------------------
    // Decodes
    // -------------------------------------------------------------------------
    logic start_acc;   // START honoured (only possible in IDLE)
    logic take_byte;   // handshake completes this cycle
    logic phase_end;   // last cycle of an SLO or SHI phase
    logic lo_done;     // low half of a bit ends, SCLK rises next
    logic hi_done;     // high half of a bit ends, the bit is delivered
    logic last_bit;    // the bit being delivered is bit CFG_LEN-1
    logic byte_end;    // the bit being delivered is bit 7 of its byte

    assign start_acc = (state == ST_IDLE)  && bus.START;
    assign take_byte = (state == ST_FETCH) && bus.BYTE_VALID;
    assign phase_end = (div_cnt == DIV_LAST);
    assign lo_done   = (state == ST_SLO) && phase_end;
    assign hi_done   = (state == ST_SHI) && phase_end;
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign byte_end  = (bit_idx == 3'd7);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.START) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.BYTE_VALID) begin
                    state_nxt = ST_SLO;
                end
            end
            ST_SLO: begin
                if (phase_end) begin
                    state_nxt = ST_SHI;
                end
            end
            ST_SHI: begin
                if (phase_end) begin
                    if (last_bit) begin
                        state_nxt = ST_FINISH;
                    end else if (byte_end) begin
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_SLO;
                    end
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Phase divider: counts cycles within SLO / SHI, restarts on every phase
    // boundary and rests at zero everywhere else.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            div_cnt <= '0;
        end else if (((state == ST_SLO) || (state == ST_SHI)) && !phase_end) begin
            div_cnt <= div_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Bit accounting. bit_idx is 3 bits wide so it wraps to 0 on its own when
    // a byte is exhausted, ready for the next fetched byte.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (start_acc) begin
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (hi_done) begin
            bit_cnt <= bit_cnt + 1'b1;
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Shift register. Its bit 0 drives CFG_DATA directly, so the data pin is
    // flop-driven and only moves when a byte is loaded (SCLK low in FETCH) or
    // on the same edge that drops SCLK at the end of a bit. When a byte is
    // exhausted the register is left alone, keeping CFG_DATA steady through
    // the fetch.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            shreg <= '0;
        end else if (take_byte) begin
            shreg <= bus.BYTE_DATA;
        end else if (hi_done && !last_bit && !byte_end) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    // -------------------------------------------------------------------------
    // Pin-level control outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            cfg_sclk_q <= 1'b0;
        end else if (lo_done) begin
            cfg_sclk_q <= 1'b1;
        end else if (hi_done) begin
            cfg_sclk_q <= 1'b0;
        end
    end

    // CFG_EN holds the last completed configuration active while idle and
    // drops only when a new load is accepted.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            cfg_en_q <= 1'b0;
        end else if (start_acc) begin
            cfg_en_q <= 1'b0;
        end else if (state == ST_FINISH) begin
            cfg_en_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            busy_q <= 1'b0;
        end else if (start_acc) begin
            busy_q <= 1'b1;
        end else if (state == ST_FINISH) begin
            busy_q <= 1'b0;
        end
    end

    // DONE is registered on the edge that enters FINISH, so it is high for
    // exactly the FINISH cycle.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            done_q <= 1'b0;
        end else begin
            done_q <= hi_done && last_bit;
        end
    end

    assign bus.BYTE_READY = (state == ST_FETCH);
    assign bus.CFG_DATA   = shreg[0];
    assign bus.CFG_SCLK   = cfg_sclk_q;
    assign bus.CFG_EN     = cfg_en_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;

endmodule

// File: doc/pal_cfg_serializer.md
Name: pal_cfg_serializer

Overview:
Transmit end of the PAL configuration chain. Accepts the PAL configuration bitstream as bytes over a valid/ready handshake and serializes it onto the PAL's config interface: data bit, generated shift clock, and apply-enable. It lives on the host/loader side and drives the PAL's CFG, CLK and EN pins. When loading is complete it raises EN so that the fabric uses the new configuration.

Parameters:
CFG_LEN, 280, total configuration bits (2*N*P AND-plane + P*M OR-plane; 280 for N=8, P=14, M=4)
CLK_DIV, 2, CFG_SCLK half-period in CLK cycles (>=1)

Ports:
CLK  in  1  system clock; all logic on rising edge
RES_N  in  1  asynchronous active-low reset
START  in  1  begin a load; sampled only in IDLE
BYTE_DATA  in  8  config byte; bit 0 is shifted first
BYTE_VALID  in  1  BYTE_DATA valid
BYTE_READY  out  1  serializer can accept a byte
CFG_DATA  out  1  serial config bit to PAL CFG
CFG_SCLK  out  1  generated shift clock to PAL CLK
CFG_EN  out  1  apply-enable to PAL EN
BUSY  out  1  load in progress
DONE  out  1  one-cycle pulse when load completes

Behaviour:
- Reset (async, RES_N=0): all outputs 0; FSM=IDLE; bit counter, divider and shift register cleared. Reset mid-load aborts the load. CFG_EN stays low until a new load completes.
- NBYTES = ceil(CFG_LEN/8). In the last byte, bits at positions >= CFG_LEN mod 8 (when nonzero) are discarded and never shifted.
- Bit count width: clog2(CFG_LEN+1). Divider width: clog2(CLK_DIV+1).
- FSM states: IDLE, FETCH, SLO, SHI, FINISH.
- IDLE: BUSY=0, BYTE_READY=0. START=1 -> FETCH next cycle. In the same edge, CFG_EN<=0, BUSY<=1, bit counter<=0.
- FETCH: BYTE_READY=1 (combinational from state). CFG_SCLK is held low.
  - BYTE_VALID=1 at a rising edge: the byte is loaded into the 8-bit shift register, CFG_DATA<=BYTE_DATA[0], FSM moves to SLO.
  - BYTE_VALID=0: stall indefinitely. No timeout.
- SLO: CFG_SCLK=0 for CLK_DIV cycles with CFG_DATA stable, then SHI.
- SHI: CFG_SCLK=1 for CLK_DIV cycles. This produces the PAL sample edge. On exit:
  - bit counter+1 and byte-bit index+1.
  - counter==CFG_LEN -> FINISH.
  - else byte exhausted (8 bits) -> FETCH.
  - else shift right, CFG_DATA<=next bit, SLO.
- Per bit: exactly 2*CLK_DIV cycles when bytes are available. CFG_DATA changes only while CFG_SCLK=0, so setup and hold are each >= CLK_DIV cycles.
- FINISH (1 cycle): CFG_SCLK=0, CFG_EN<=1, DONE=1 for this cycle only, BUSY<=0, then IDLE.
- CFG_EN stays 1 in IDLE after a completed load and drops on the next accepted START.
- START while BUSY: ignored. BYTE_VALID outside FETCH: ignored, and no byte is consumed.
- START and a completing FINISH in the same cycle: START is ignored. It is honoured only in IDLE.
- Exactly CFG_LEN rising edges of CFG_SCLK per load. No extra edges at start, end or reset.
- Output drive: CFG_SCLK, CFG_DATA, CFG_EN, DONE and BUSY are driven from flops (glitch-free, since they leave the chip). BYTE_READY may be decoded from state.

Test Plan:
- Reset: RES_N=0 mid-SHI -> all outputs 0 within the same cycle (asynchronous). After release: IDLE, no CFG_SCLK edges, CFG_EN=0.
- CFG_LEN=12, CLK_DIV=1, bytes 0xA5 then 0x0F, VALID always high -> CFG_DATA at the 12 CFG_SCLK rises = 1,0,1,0,0,1,0,1,1,1,1,1. Each bit lasts 2 CLK cycles. Exactly 2 handshakes. DONE pulses once. CFG_EN=1 afterwards.
- Default CFG_LEN=280, CLK_DIV=2, random bytes -> 35 handshakes, 280 CFG_SCLK rises. A model PAL shift chain matches the input stream. Unstalled load takes 280*4 + handshake + FINISH cycles.
- Back-pressure: BYTE_VALID held low 10 cycles at each FETCH -> CFG_SCLK stays 0 during stalls, bit sequence unchanged, no lost or duplicated bits.
- START pulsed during BUSY and in the same cycle as FINISH -> ignored. A new START in IDLE -> CFG_EN drops to 0 the next cycle and a fresh 280-bit load runs.
- CLK_DIV=3 -> CFG_SCLK high 3 / low 3. CFG_DATA transitions only while CFG_SCLK=0 (assertion checked every cycle).
